// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and geometry for the D-cache.
// Index/tag widths are derived from the block count.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_ALLOC
  } state_e;

  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W = 2;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 30;
  localparam int MEM_ADDR_W = ADDR_W - OFFSET_W;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int tag_w(input int n);
    return ADDR_W - OFFSET_W - $clog2(n);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: processor-side request bus plus memory-side block bus.
// slave = the cache, master = MEM stage and memory model.
interface dcache_if #(
  parameter int BIT_W = 32
);
  import dcache_pkg::*;

  logic                  proc_read;
  logic                  proc_write;
  logic [ADDR_W-1:0]     proc_addr;
  logic [BIT_W-1:0]      proc_wdata;
  logic [BIT_W-1:0]      proc_rdata;
  logic                  proc_stall;
  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  proc_read, proc_write,
    input  proc_addr, proc_wdata,
    output proc_rdata, proc_stall,
    output mem_read, mem_write,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output proc_read, proc_write,
    output proc_addr, proc_wdata,
    input  proc_rdata, proc_stall,
    input  mem_read, mem_write,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage, combinational read,
// one write port doing either a word store or a full-line fill.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int BIT_W      = 32,
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [WORDS_PER_LINE-1:0][BIT_W-1:0] rd_data,
  input  logic                 we_word,
  input  logic [OFFSET_W-1:0]  wr_off,
  input  logic [BIT_W-1:0]     wr_word,
  input  logic                 we_fill,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [WORDS_PER_LINE-1:0][BIT_W-1:0] fill_data
);

  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [NUM_BLOCKS];
  logic [WORDS_PER_LINE-1:0][BIT_W-1:0] data_q [NUM_BLOCKS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (we_fill) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (we_word) begin
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Payload arrays carry no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (we_fill) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (we_word) begin
      data_q[idx][wr_off] <= wr_word;
    end
  end

endmodule

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped write-back/write-allocate D-cache.
// Define DCACHE_PERF_CNT_EN to add hit_cnt/miss_cnt counters.
module dcache_direct
  import dcache_pkg::*;
#(
  parameter int BIT_W      = 32,
  parameter int NUM_BLOCKS = 8
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DCACHE_PERF_CNT_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  dcache_if.slave     bus
);

  localparam int IDX_W = idx_w(NUM_BLOCKS);
  localparam int TAG_W = tag_w(NUM_BLOCKS);

  typedef logic [WORDS_PER_LINE-1:0][BIT_W-1:0] line_t;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  line_t                 mem_wdata_q, mem_wdata_d;

  logic                  idle, req, hit, miss_go;
  logic [ADDR_W-1:0]     cur_addr;
  logic [OFFSET_W-1:0]   off;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  line_t                 rd_data;
  logic                  we_word, we_fill;

  // Outside S_IDLE the latched miss address steers the array.
  assign idle     = state_q == S_IDLE;
  assign req      = bus.proc_read | bus.proc_write;
  assign cur_addr = idle ? bus.proc_addr : addr_q;
  assign off      = cur_addr[OFFSET_W-1:0];
  assign idx      = cur_addr[OFFSET_W +: IDX_W];
  assign tag      = cur_addr[ADDR_W-1 -: TAG_W];
  assign hit      = rd_valid & (rd_tag == tag);
  assign miss_go  = idle & req & ~hit;
  assign we_word  = idle & bus.proc_write & hit;
  assign we_fill  = (state_q == S_ALLOC) & bus.mem_ready;

  dcache_line_array #(
    .BIT_W      (BIT_W),
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .we_word   (we_word),
    .wr_off    (off),
    .wr_word   (bus.proc_wdata),
    .we_fill   (we_fill),
    .fill_tag  (tag),
    .fill_data (line_t'(bus.mem_rdata))
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss_go) begin
          addr_d = bus.proc_addr;
          if (rd_valid && rd_dirty) begin
            state_d     = S_WB;
            mem_write_d = 1'b1;
            mem_addr_d  = {rd_tag, idx};
            mem_wdata_d = rd_data;
          end else begin
            state_d    = S_ALLOC;
            mem_read_d = 1'b1;
            mem_addr_d = {tag, idx};
          end
        end
      end
      S_WB: begin
        if (bus.mem_ready) begin
          state_d     = S_ALLOC;
          mem_write_d = 1'b0;
          mem_wdata_d = '0;
          mem_read_d  = 1'b1;
          mem_addr_d  = {tag, idx};
        end
      end
      S_ALLOC: begin
        if (bus.mem_ready) begin
          state_d    = S_IDLE;
          mem_read_d = 1'b0;
          mem_addr_d = '0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.proc_stall = idle ? (req & ~hit) : 1'b1;
  assign bus.proc_rdata = rd_data[off];
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (idle && req && hit && hit_cnt_q != '1)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss_go && miss_cnt_q != '1)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// tb_dcache_direct: directed vectors for the direct-mapped D-cache.
// Memory model answers misses after a chosen number of cycles.
module tb_dcache_direct;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if #(.BIT_W(32)) bus ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_direct #(
    .BIT_W      (32),
    .NUM_BLOCKS (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef DCACHE_PERF_CNT_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  int           r_stalls, r_wbs, r_als;
  bit           r_done;
  logic [31:0]  r_rdata;
  logic [27:0]  r_wb_addr, r_al_addr;
  logic [127:0] r_wb_data;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts and ends at posedge+1; services mem_read/mem_write.
  task automatic run_req(input logic rd, input logic wr,
                         input logic [29:0] a, input logic [31:0] wd,
                         input int nwb, input int nal,
                         input logic [127:0] line);
    r_stalls = 0; r_wbs = 0; r_als = 0; r_done = 1'b0;
    r_rdata = '0; r_wb_addr = '0; r_wb_data = '0; r_al_addr = '0;
    bus.proc_read = rd;
    bus.proc_write = wr;
    bus.proc_addr = a;
    bus.proc_wdata = wd;
    for (int c = 0; c < 64 && !r_done; c++) begin
      @(negedge clk);
      if (!bus.proc_stall) begin
        r_done = 1'b1;
        r_rdata = bus.proc_rdata;
      end else begin
        r_stalls++;
        if (bus.mem_write) begin
          if (r_wbs == 0) begin
            r_wb_addr = bus.mem_addr;
            r_wb_data = bus.mem_wdata;
          end
          r_wbs++;
          if (r_wbs == nwb) bus.mem_ready = 1'b1;
        end else if (bus.mem_read) begin
          if (r_als == 0) r_al_addr = bus.mem_addr;
          r_als++;
          if (r_als == nal) begin
            bus.mem_rdata = line;
            bus.mem_ready = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
    end
    bus.proc_read = 1'b0;
    bus.proc_write = 1'b0;
    chk("req_done", 128'(r_done), 128'd1);
  endtask

  task automatic chk_perf(input string tagname);
`ifdef DCACHE_PERF_CNT_EN
    chk({tagname, "_hit_cnt"}, 128'(hit_cnt), 128'(exp_hit));
    chk({tagname, "_miss_cnt"}, 128'(miss_cnt), 128'(exp_miss));
`else
    $display("%s: counters not built, expected hit=%0d miss=%0d",
             tagname, exp_hit, exp_miss);
`endif
  endtask

  initial begin
    bit found;
    vt[0] = '{1'b1, 1'b0, 30'h11, 32'h0, 32'h2};
    vt[1] = '{1'b1, 1'b0, 30'h13, 32'h0, 32'h4};
    vt[2] = '{1'b0, 1'b1, 30'h12, 32'hDEAD_BEEF, 32'h0};
    vt[3] = '{1'b1, 1'b1, 30'h11, 32'h5, 32'h0};
    vt[4] = '{1'b1, 1'b0, 30'h12, 32'h0, 32'hDEAD_BEEF};
    vt[5] = '{1'b1, 1'b0, 30'h11, 32'h0, 32'h5};
    vt[6] = '{1'b1, 1'b0, 30'h10, 32'h0, 32'h1};

    bus.proc_read = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr = '0;
    bus.proc_wdata = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_read", 128'(bus.mem_read), 128'd0);
    chk("rst_mem_write", 128'(bus.mem_write), 128'd0);
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 128'd0);
    chk("rst_stall", 128'(bus.proc_stall), 128'd0);
    @(posedge clk);
    #1;

    // Cold read miss, memory answers on the third cycle.
    run_req(1'b1, 1'b0, 30'h10, 32'h0, 0, 3,
            {32'h4, 32'h3, 32'h2, 32'h1});
    chk("cold_stalls", 128'(r_stalls), 128'd4);
    chk("cold_wbs", 128'(r_wbs), 128'd0);
    chk("cold_als", 128'(r_als), 128'd3);
    chk("cold_addr", 128'(r_al_addr), 128'h4);
    chk("cold_rdata", 128'(r_rdata), 128'h1);
    exp_hit++;
    exp_miss++;

    for (int i = 0; i < 7; i++) begin
      run_req(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, 0, 0, '0);
      chk($sformatf("vec%0d_stall", i), 128'(r_stalls), 128'd0);
      if (vt[i].rd && !vt[i].wr)
        chk($sformatf("vec%0d_rdata", i), 128'(r_rdata),
            128'(vt[i].exp));
      exp_hit++;
    end

    // Dirty conflict miss: write-back then refill.
    run_req(1'b1, 1'b0, 30'h32, 32'h0, 2, 2,
            {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("dirty_stalls", 128'(r_stalls), 128'd5);
    chk("dirty_wbs", 128'(r_wbs), 128'd2);
    chk("dirty_wb_addr", 128'(r_wb_addr), 128'h4);
    chk("dirty_wb_data", r_wb_data,
        {32'h4, 32'hDEAD_BEEF, 32'h5, 32'h1});
    chk("dirty_als", 128'(r_als), 128'd2);
    chk("dirty_al_addr", 128'(r_al_addr), 128'hC);
    chk("dirty_rdata", 128'(r_rdata), 128'hA2);
    exp_hit++;
    exp_miss++;
    chk_perf("after_dirty");

    run_req(1'b0, 1'b1, 30'h33, 32'hDDDD, 0, 0, '0);
    chk("w33_stalls", 128'(r_stalls), 128'd0);

    // Reset lands while the write-back is outstanding.
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h12;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_write) found = 1'b1;
    end
    chk("wb_seen", 128'(found), 128'd1);
    rst = 1'b1;
    #1;
    chk("rstwb_mem_write", 128'(bus.mem_write), 128'd0);
    chk("rstwb_mem_read", 128'(bus.mem_read), 128'd0);
    chk("rstwb_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk("rstwb_mem_wdata", bus.mem_wdata, 128'd0);
    bus.proc_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_hit = 0;
    exp_miss = 0;

    run_req(1'b1, 1'b0, 30'h12, 32'h0, 1, 1,
            {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    chk("post_rst_stalls", 128'(r_stalls), 128'd2);
    chk("post_rst_wbs", 128'(r_wbs), 128'd0);
    chk("post_rst_als", 128'(r_als), 128'd1);
    chk("post_rst_addr", 128'(r_al_addr), 128'h4);
    chk("post_rst_rdata", 128'(r_rdata), 128'hB2);
    exp_hit++;
    exp_miss++;
    chk_perf("after_rst");

    // Stray mem_ready while idle must be ignored.
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("stray_mem_read", 128'(bus.mem_read), 128'd0);
    chk("stray_mem_write", 128'(bus.mem_write), 128'd0);
    chk("stray_mem_addr", 128'(bus.mem_addr), 128'd0);
    @(posedge clk);
    #1;
    run_req(1'b1, 1'b0, 30'h12, 32'h0, 0, 0, '0);
    chk("stray_hit_stalls", 128'(r_stalls), 128'd0);
    chk("stray_hit_rdata", 128'(r_rdata), 128'hB2);
    exp_hit++;
    chk_perf("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_direct.md
# dcache_direct

Direct-mapped, write-back, write-allocate data cache that serves as the responder on the processor-side D-cache interface driven by the MEM pipeline stage. It accepts word-addressed read/write requests, answers hits in the request cycle, and holds `proc_stall` high while it runs a block write-back and/or refill against a 128-bit, slow main memory with a `mem_ready` handshake. It sits between the MEM stage and the memory model/arbiter.

## Interface
- `BIT_W`, 32: processor data word width.
- `NUM_BLOCKS`, 8: cache lines (power of two); 4 words per line.
- `clk  in  1`: sole clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `proc_read  in  1`: read request (held until `proc_stall` low).
- `proc_write  in  1`: write request (held until `proc_stall` low).
- `proc_addr  in  30`: word address; [1:0] word offset, [4:2] index, [29:5] tag.
- `proc_wdata  in  BIT_W`: store data, stored as presented (no byte swap).
- `proc_rdata  out  BIT_W`: load data, valid in the cycle `proc_stall` is low.
- `proc_stall  out  1`: request not complete this cycle.
- `mem_read  out  1`: block refill request.
- `mem_write  out  1`: block write-back request.
- `mem_addr  out  28`: block address {tag, index}.
- `mem_wdata  out  128`: victim line; word 0 in [31:0].
- `mem_rdata  in  128`: refill line; word 0 in [31:0].
- `mem_ready  in  1`: one-cycle pulse, memory op complete.

## Operation
- Per line: valid, dirty, tag (25 b), data (4×32 b). Only valid/dirty are reset (to 0); tag/data arrays are not reset.
- FSM states: S_IDLE, S_WB, S_ALLOC.
- S_IDLE: hit = valid[idx] & tag match. Request with hit → `proc_stall`=0; read returns word combinationally; write updates word at clock edge and sets dirty. Miss → `proc_stall`=1; next state S_WB if victim valid&dirty, else S_ALLOC.
- S_WB: `mem_write`=1, `mem_addr`={stored tag, idx}, `mem_wdata`=victim line; on `mem_ready` → S_ALLOC.
- S_ALLOC: `mem_read`=1, `mem_addr`={req tag, idx}; on `mem_ready` write `mem_rdata` into line, tag←req tag, valid←1, dirty←0 → S_IDLE, where the request now hits and completes.
- `proc_stall` = (`proc_read`|`proc_write`) & ~hit in S_IDLE; 1 in S_WB/S_ALLOC.
- `proc_read` and `proc_write` together: write takes priority, read ignored.
- Request dropped while in S_WB/S_ALLOC: the started memory op still completes; line is filled.
- `mem_addr`, `mem_wdata` drive 0 outside S_WB/S_ALLOC (mem_wdata 0 outside S_WB).

## Timing
- Reset (async, any state, including mid-transfer): state S_IDLE, `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0, all lines invalid/clean; `proc_stall`=0 while no request; `proc_rdata` don't-care.
- Hit: 0 stall cycles.
- Clean miss: stall = 1 (S_IDLE) + N_alloc (cycles until `mem_ready` incl. that cycle) cycles, completing in first S_IDLE cycle after.
- Dirty miss: adds N_wb cycles for S_WB.
- `mem_read`/`mem_write` are functions of registered state: glitch-free, held until and including the `mem_ready` cycle, deasserted the cycle after.
- `mem_ready` outside S_WB/S_ALLOC is ignored.

## Configuration
- `DCACHE_PERF_CNT_EN`: when defined, adds 32-bit output ports `hit_cnt` and `miss_cnt`, incremented once per completed-hit cycle and once per S_IDLE→S_WB/S_ALLOC transition, saturating at 0xFFFF_FFFF, cleared by `rst`. When undefined, ports and counters are absent; functional behaviour identical.

## Structure
- Shared package `dcache_pkg`: state encoding (S_IDLE/S_WB/S_ALLOC), `LINE_W`=128, `WORDS_PER_LINE`=4, `OFFSET_W`=2, index/tag width constants derived from `NUM_BLOCKS`.
- One sub-module: `dcache_line_array` (valid/dirty/tag/data storage, combinational read, single write port for word update or full-line fill).

## Test plan
- Reset then read 0x0000_0010 with memory returning line {0x4,0x3,0x2,0x1} after 3 cycles → `mem_read` with `mem_addr`=0x000_0004, stall 1+3 cycles, `proc_rdata`=0x1.
- Read 0x0000_0011 right after → hit, no stall, `proc_rdata`=0x2.
- Write 0xDEAD_BEEF to 0x0000_0012, then read 0x0000_0032 (same index, new tag) → `mem_write` with `mem_addr`=0x000_0004, `mem_wdata`[95:64]=0xDEAD_BEEF, then `mem_read` `mem_addr`=0x000_000C.
- Assert `rst` during S_WB → `mem_write` falls immediately, next read of 0x0000_0012 misses with `mem_read` (no write-back).
- Simultaneous `proc_read`/`proc_write` hit at 0x0000_0011, wdata 0x5 → line word updated to 0x5, dirty set.
- With `DCACHE_PERF_CNT_EN`: sequence above → `hit_cnt`, `miss_cnt` match scoreboard counts exactly.
